// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter in front of a single UART transmitter.
// Owns the transmitter from accept to tx_done, aborting when the transfer exceeds TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic [1:0] sent,
  output logic       timeout_err,
  output logic [1:0] fsm_state
);

  // Handshake: a requester's byte is taken on the rising edge where its valid
  // and ready are both 1; ready is combinational and only ever high in IDLE.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  sent_q, sent_d;
  logic        to_q, to_d;

  logic        accept;
  logic        win1;
  logic        timeout_hit;
  logic [15:0] cnt_inc;

  // last_q = 1 means port 1 was served last, so port 0 wins the next tie.
  assign win1        = req1_valid && (!req0_valid || !last_q);
  assign accept      = (state_q == IDLE) && rst_n && !tx_busy && (req0_valid || req1_valid);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign req0_ready  = accept && !win1;
  assign req1_ready  = accept && win1;
  assign tx_start    = (state_q == START);
  assign tx_data     = data_q;
  assign grant       = grant_q;
  assign sent        = sent_q;
  assign timeout_err = to_q;
  assign fsm_state   = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    sent_d  = 2'b00;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = win1 ? req1_data : req0_data;
          grant_d = win1 ? 2'b10 : 2'b01;
          cnt_d   = 16'd0;
          state_d = START;
        end
      end
      START, WAIT_DONE: begin
        // Completion takes priority over a coincident timeout.
        if (tx_done) begin
          sent_d  = grant_q;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == START && tx_busy) begin
            state_d = WAIT_DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
      data_q  <= 8'h00;
      grant_q <= 2'b00;
      sent_q  <= 2'b00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      sent_q  <= sent_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transmitter model answers tx_start,
// directed vectors push expected accept/complete records, a monitor pops and compares.
module tb_uart_tx_arbiter;

  localparam int TO = 128;
  localparam int W  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic [1:0] grant;
  logic [1:0] sent;
  logic       timeout_err;
  logic [1:0] fsm_state;

  // Expected record: {kind, port one-hot, tx byte, cycles since accept}
  // kind 1 = accept, 2 = sent, 3 = timeout.
  logic [W-1:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  logic [1:0] owner = 2'b00;

  // Transmitter model controls
  int   busy_dly = 2;
  int   done_dly = 4;
  bit   never_done = 1'b0;
  bit   ext_busy = 1'b0;
  logic m_busy = 1'b0;
  int   m_phase = 0;
  int   m_cnt = 0;
  int   starts = 0;
  bit   first = 1'b0;

  assign tx_busy = m_busy | ext_busy;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant      (grant),
    .sent       (sent),
    .timeout_err(timeout_err),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [1:0] port,
                      input logic [7:0] data, input logic [7:0] lat);
    exp_q.push_back({kind, port, data, lat});
  endtask

  task automatic sb_compare(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h expected nothing", name, act);
    end else begin
      check(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  // Transmitter model: busy busy_dly cycles after start, done done_dly cycles later
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      m_phase = 0;
      m_busy  = 1'b0;
      tx_done = 1'b0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (tx_start) begin
          m_cnt  = 1;
          starts = 1;
          if (busy_dly == 1) begin
            m_busy = 1'b1; m_phase = 2; m_cnt = 0; first = 1'b1;
          end else begin
            m_phase = 1;
          end
        end
        1: begin
          m_cnt++;
          if (tx_start) starts++;
          if (m_cnt == busy_dly) begin
            m_busy = 1'b1; m_phase = 2; m_cnt = 0; first = 1'b1;
          end
        end
        2: begin
          if (grant == 2'b00) begin
            m_busy  = 1'b0;
            m_phase = 0;
          end else begin
            if (first) begin
              check("start_len", 32'({tx_start, 8'(starts)}), 32'({1'b0, 8'(busy_dly)}));
              first = 1'b0;
            end
            m_cnt++;
            if (!never_done && m_cnt == done_dly) begin
              tx_done = 1'b1;
              m_phase = 3;
            end
          end
        end
        default: begin
          tx_done = 1'b0;
          m_busy  = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Monitor: completions first, then a possible accept in the same cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (sent != 2'b00 || timeout_err) begin
        sb_compare("complete", {timeout_err ? 2'd3 : 2'd2, timeout_err ? owner : sent,
                                tx_data, 8'(cyc - acc_cyc)});
        check("grant_idle", 32'(grant), 32'd0);
      end
      if (req0_ready || req1_ready) begin
        sb_compare("accept", {2'd1, req1_ready, req0_ready,
                              req1_ready ? req1_data : req0_data, 8'd0});
        acc_cyc = cyc;
        acc_cnt++;
      end
      if (grant != 2'b00) owner = grant;
    end
  end

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    if (acc_cnt < target) check("accept_wait", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic drive_edge();
    @(posedge clk); #2;
  endtask

  initial begin
    int t;
    // Reset state
    #1 rst_n = 1'b0;
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_out", 32'({tx_start, sent, timeout_err, req0_ready, req1_ready}), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_state", 32'(fsm_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: 11,22,11,22
    busy_dly = 1; done_dly = 3;
    push(2'd1, 2'b01, 8'h11, 8'd0); push(2'd2, 2'b01, 8'h11, 8'd5);
    push(2'd1, 2'b10, 8'h22, 8'd0); push(2'd2, 2'b10, 8'h22, 8'd5);
    push(2'd1, 2'b01, 8'h11, 8'd0); push(2'd2, 2'b01, 8'h11, 8'd5);
    push(2'd1, 2'b10, 8'h22, 8'd0); push(2'd2, 2'b10, 8'h22, 8'd5);
    drive_edge();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    t = acc_cnt + 4;
    wait_acc(t);
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Single port, long transfer
    busy_dly = 2; done_dly = 100;
    push(2'd1, 2'b01, 8'hA5, 8'd0); push(2'd2, 2'b01, 8'hA5, 8'd103);
    drive_edge();
    req0_valid = 1'b1; req0_data = 8'hA5;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req0_valid = 1'b0;
    wait_drain();

    // Timeout on port 1
    busy_dly = 2; never_done = 1'b1;
    push(2'd1, 2'b10, 8'h3C, 8'd0); push(2'd3, 2'b10, 8'h3C, 8'(TO + 1));
    drive_edge();
    req1_valid = 1'b1; req1_data = 8'h3C;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req1_valid = 1'b0;
    wait_drain();
    never_done = 1'b0;

    // Tie after timeout on port 1 goes to port 0
    busy_dly = 1; done_dly = 3;
    push(2'd1, 2'b01, 8'h44, 8'd0); push(2'd2, 2'b01, 8'h44, 8'd5);
    drive_edge();
    req0_valid = 1'b1; req0_data = 8'h44;
    req1_valid = 1'b1; req1_data = 8'h55;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // External busy blocks acceptance
    busy_dly = 2; done_dly = 4;
    drive_edge();
    ext_busy = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h5C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("busy_block", 32'({req0_ready, req1_ready}), 32'd0);
    end
    push(2'd1, 2'b10, 8'h5C, 8'd0); push(2'd2, 2'b10, 8'h5C, 8'd7);
    drive_edge();
    ext_busy = 1'b0;
    @(negedge clk); #1;
    check("busy_release", 32'(req1_ready), 32'd1);
    drive_edge();
    req1_valid = 1'b0;
    wait_drain();

    // tx_done on the same cycle as the timeout threshold
    busy_dly = 2; done_dly = TO - 2;
    push(2'd1, 2'b01, 8'hC3, 8'd0); push(2'd2, 2'b01, 8'hC3, 8'(TO + 1));
    drive_edge();
    req0_valid = 1'b1; req0_data = 8'hC3;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req0_valid = 1'b0;
    wait_drain();

    // Asynchronous reset during WAIT_DONE discards the transfer
    busy_dly = 2; done_dly = 50;
    push(2'd1, 2'b10, 8'h77, 8'd0);
    drive_edge();
    req1_valid = 1'b1; req1_data = 8'h77;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req1_valid = 1'b0;
    repeat (10) @(posedge clk);
    check("pre_rst_state", 32'(fsm_state), 32'd2);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_out", 32'({tx_start, sent, timeout_err}), 32'd0);
    check("arst_data", 32'(tx_data), 32'h00);
    req0_valid = 1'b1; req0_data = 8'h99;
    req1_valid = 1'b1; req1_data = 8'hAA;
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    check("rst_pending", 32'(exp_q.size()), 32'd0);
    busy_dly = 1; done_dly = 3;
    push(2'd1, 2'b01, 8'h99, 8'd0); push(2'd2, 2'b01, 8'h99, 8'd5);
    @(negedge clk);
    rst_n = 1'b1;
    t = acc_cnt + 1;
    wait_acc(t);
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16384, is the maximum clk cycles from tx_start assertion to tx_done before the arbiter aborts (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte; stable while req0_valid=1 and req0_ready=0.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a byte to send.
REQ-008 req1_data  input  8  requester 1 byte; same stability rule as req0_data.
REQ-009 req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 tx_start  output  1  drives the transmitter start input.
REQ-011 tx_data  output  8  drives the transmitter in input; registered.
REQ-012 tx_busy  input  1  transmitter busy output.
REQ-013 tx_done  input  1  transmitter done output.
REQ-014 grant  output  2  one-hot owner of the transmitter (bit0 = port 0); 2'b00 when idle.
REQ-015 sent  output  2  one-cycle pulse on the owner's bit when its byte completes.
REQ-016 timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT_DONE; one state register, no other control state except the last-served pointer and timeout counter.
REQ-018 IDLE: when tx_busy=0 and at least one valid is high, the arbiter SHALL assert ready for exactly one winner combinationally, latch its data into tx_data, set grant to the winner and move to START on the same edge.
REQ-019 Winner selection: a single valid wins; with both valid, the port not equal to last-served wins (round-robin).
REQ-020 IDLE with tx_busy=1 SHALL assert no ready and stay in IDLE.
REQ-021 START: tx_start=1; held every cycle until tx_busy=1 is sampled, then move to WAIT_DONE with tx_start=0 on the next cycle.
REQ-022 WAIT_DONE: tx_start=0; on tx_done=1 pulse sent[owner] for one cycle, update last-served to owner, clear grant, return to IDLE.
REQ-023 Earliest next acceptance is the cycle after returning to IDLE (no back-to-back accept in the done cycle).
REQ-024 Timeout counter (16 bits) SHALL clear on entry to START and increment each cycle in START and WAIT_DONE; saturates, never wraps.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 without tx_done, pulse timeout_err, drop tx_start, update last-served to owner, clear grant, return to IDLE; no sent pulse.
REQ-026 tx_done and the timeout condition in the same cycle: tx_done wins, sent pulses, timeout_err stays 0.
REQ-027 tx_done seen in START (before tx_busy) SHALL be treated as completion, same as REQ-022.
REQ-028 A valid dropping while not ready is legal; that request is simply not served.
REQ-029 ready outputs SHALL never be asserted outside IDLE; at most one ready per cycle.
REQ-030 tx_data SHALL hold its value from acceptance until the next acceptance.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, tx_start=0, tx_data=8'h00, grant=2'b00, sent=2'b00, timeout_err=0, counter=0, last-served=port 1 (so port 0 wins the first tie).
REQ-032 Reset mid-transfer SHALL discard the transfer silently (no sent, no timeout_err) and ready outputs SHALL be 0 while rst_n=0.

Verification
REQ-033 Single port: req0_valid=1, data=8'hA5, transmitter model busy 2 cycles after start, done 100 cycles later -> req0_ready 1 cycle, tx_data=8'hA5, tx_start held until busy, sent=2'b01 pulse, grant back to 00.
REQ-034 Tie after reset: both valid, data 8'h11/8'h22 held -> sequence on tx_data 11,22,11,22 with grant 01,10,01,10 and alternating sent pulses.
REQ-035 Timeout: TIMEOUT_CYCLES=8, model never asserts done -> timeout_err pulses exactly 8 cycles after START entry, no sent, next tie goes to other port.
REQ-036 Collision: tx_done asserted in the same cycle the counter hits TIMEOUT_CYCLES-1 -> sent pulses, timeout_err=0.
REQ-037 Busy external: tx_busy=1 while req1_valid=1 in IDLE -> req1_ready stays 0 until tx_busy falls, then accepted next cycle.
REQ-038 Reset in WAIT_DONE: assert rst_n=0 asynchronously mid-cycle -> tx_start, grant, sent, timeout_err 0 immediately; after release, port 0 wins first tie.
